// File: rtl/aha_clk_div_sel_ctrl.sv
// Glitch-free divided-clock select sequencer: gate off, align to divider phase, switch, settle, re-enable.
// Optional feature macro AHA_CLK_SEL_PENDING_EN adds a one-entry pending request buffer.
module aha_clk_div_sel_ctrl #(
  parameter logic [2:0]  RESET_SEL       = 3'd0,
  parameter int unsigned GATE_OFF_CYCLES = 4,
  parameter int unsigned SETTLE_CYCLES   = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ_VALID,
  input  logic [2:0] REQ_SEL,
  output logic       REQ_READY,
  output logic [2:0] DIV_SEL,
  output logic       CLK_EN,
  output logic       BUSY,
  output logic       ACK,
  output logic       ERR
);

  localparam logic [3:0] GATE_LOAD   = 4'(GATE_OFF_CYCLES - 1);
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [2:0] MAX_SEL     = 3'd5;
  localparam logic [4:0] ALIGN_PHASE = 5'h1F;

  typedef enum logic [2:0] {S_IDLE, S_GATE, S_ALIGN, S_SWITCH, S_SETTLE} state_t;

  state_t     state_q, state_d;
  logic [4:0] phase_q, phase_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] target_q, target_d;
  logic [2:0] div_sel_q, div_sel_d;
  logic       clk_en_q, clk_en_d;
  logic       busy_q, busy_d;
  logic       ack_q, ack_d;
  logic       err_q, err_d;
  logic       ready_q, ready_d;
  logic       accept;
  logic       cmd_valid;
  logic [2:0] cmd_sel;
`ifdef AHA_CLK_SEL_PENDING_EN
  logic       pend_q, pend_d;
  logic [2:0] pend_sel_q, pend_sel_d;
`endif

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q + 5'd1;
    cnt_d     = cnt_q;
    target_d  = target_q;
    div_sel_d = div_sel_q;
    clk_en_d  = clk_en_q;
    busy_d    = busy_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    accept    = REQ_VALID && ready_q;
    cmd_valid = 1'b0;
    cmd_sel   = REQ_SEL;
`ifdef AHA_CLK_SEL_PENDING_EN
    pend_d     = pend_q;
    pend_sel_d = pend_sel_q;
    // A held request takes priority in IDLE; ready is low then, so no new accept can collide.
    if (state_q == S_IDLE) begin
      if (pend_q) begin
        cmd_valid = 1'b1;
        cmd_sel   = pend_sel_q;
        pend_d    = 1'b0;
      end else begin
        cmd_valid = accept;
      end
    end else if (accept) begin
      pend_d     = 1'b1;
      pend_sel_d = REQ_SEL;
    end
`else
    cmd_valid = accept && (state_q == S_IDLE);
`endif

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_sel > MAX_SEL) begin
            err_d = 1'b1;
          end else if (cmd_sel == div_sel_q) begin
            ack_d = 1'b1;
          end else begin
            target_d = cmd_sel;
            state_d  = S_GATE;
            cnt_d    = GATE_LOAD;
            clk_en_d = 1'b0;
            busy_d   = 1'b1;
          end
        end
      end
      S_GATE: begin
        if (cnt_q == '0) state_d = S_ALIGN;
        else             cnt_d   = cnt_q - 4'd1;
      end
      S_ALIGN: begin
        if (phase_q == ALIGN_PHASE) state_d = S_SWITCH;
      end
      S_SWITCH: begin
        div_sel_d = target_q;
        state_d   = S_SETTLE;
        cnt_d     = SETTLE_LOAD;
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d  = S_IDLE;
          clk_en_d = 1'b1;
          busy_d   = 1'b0;
          ack_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef AHA_CLK_SEL_PENDING_EN
    ready_d = !pend_d;
`else
    ready_d = (state_d == S_IDLE);
`endif
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      cnt_q      <= '0;
      target_q   <= RESET_SEL;
      div_sel_q  <= RESET_SEL;
      clk_en_q   <= 1'b1;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b1;
`ifdef AHA_CLK_SEL_PENDING_EN
      pend_q     <= 1'b0;
      pend_sel_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      target_q   <= target_d;
      div_sel_q  <= div_sel_d;
      clk_en_q   <= clk_en_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
`ifdef AHA_CLK_SEL_PENDING_EN
      pend_q     <= pend_d;
      pend_sel_q <= pend_sel_d;
`endif
    end
  end

  assign REQ_READY = ready_q;
  assign DIV_SEL   = div_sel_q;
  assign CLK_EN    = clk_en_q;
  assign BUSY      = busy_q;
  assign ACK       = ack_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_aha_clk_div_sel_ctrl.sv
// Testbench for aha_clk_div_sel_ctrl: directed scenarios plus random requests against a timing model.
module tb_aha_clk_div_sel_ctrl;

  localparam logic [2:0] RSEL = 3'd0;
  localparam int G = 4;
  localparam int S = 2;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       REQ_VALID = 1'b0;
  logic [2:0] REQ_SEL = 3'd0;
  logic       REQ_READY, CLK_EN, BUSY, ACK, ERR;
  logic [2:0] DIV_SEL;
  logic [7:0] obs;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  aha_clk_div_sel_ctrl #(
    .RESET_SEL(RSEL),
    .GATE_OFF_CYCLES(G),
    .SETTLE_CYCLES(S)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .REQ_VALID(REQ_VALID),
    .REQ_SEL(REQ_SEL),
    .REQ_READY(REQ_READY),
    .DIV_SEL(DIV_SEL),
    .CLK_EN(CLK_EN),
    .BUSY(BUSY),
    .ACK(ACK),
    .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // Cycle index since the last reset edge; the divider phase is cyc mod 32.
  always @(posedge CLK) cyc <= RESET ? 0 : cyc + 1;

  assign obs = {DIV_SEL, CLK_EN, BUSY, REQ_READY, ACK, ERR};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish before limit");
    $fatal(1);
  end

  // Reference model: one in-flight switch described by the cycles at which things happen.
  logic [2:0] m_sel, m_tgt;
  bit         m_act;
  int         m_a, m_div, m_ack, m_ackp, m_errp;

  function automatic int align_cycle(int a);
    int c;
    c = a + G + 1;
    return c + ((31 - (c % 32)) % 32);
  endfunction

  function automatic logic [2:0] exp_div(int n);
    return (m_act && n >= m_div) ? m_tgt : m_sel;
  endfunction

  function automatic logic [7:0] exp_vec(int n);
    logic g;
    g = logic'(m_act && n > m_a && n < m_ack);
    return {exp_div(n), !g, g, !g, logic'((n == m_ackp) || (m_act && n == m_ack)),
            logic'(n == m_errp)};
  endfunction

  task automatic model_reset;
    m_act = 0; m_sel = RSEL; m_tgt = RSEL;
    m_a = 0; m_div = 0; m_ack = 0; m_ackp = -10; m_errp = -10;
  endtask

  task automatic model_accept(input int n, input logic [2:0] s);
    int c;
    if (m_act && n >= m_ack) begin
      m_sel = m_tgt;
      m_act = 0;
    end
    if (s > 3'd5) begin
      m_errp = n + 1;
    end else if (s == exp_div(n)) begin
      m_ackp = n + 1;
    end else begin
      c = align_cycle(n);
      m_act = 1; m_a = n; m_tgt = s;
      m_div = c + 2;
      m_ack = c + 2 + S;
    end
  endtask

  task automatic do_reset;
    @(negedge CLK);
    RESET = 1'b1;
    REQ_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    model_reset();
  endtask

  task automatic test_reset;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (obs !== {RSEL, 5'b10100}) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got=%b required=%b", cyc, obs, {RSEL, 5'b10100});
      end
      @(negedge CLK);
    end
  endtask

`ifndef AHA_CLK_SEL_PENDING_EN
  task automatic test_same_sel;
    REQ_SEL = RSEL;
    REQ_VALID = 1'b1;
    model_accept(cyc, RSEL);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    checks++;
    if ({ACK, ERR, BUSY, CLK_EN} !== 4'b1001) begin
      errors++;
      $display("FAIL same_sel_ack got ACK,ERR,BUSY,CLK_EN=%b required=1001", {ACK, ERR, BUSY, CLK_EN});
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      checks++;
      if ({ACK, BUSY, CLK_EN} !== 3'b001 || obs !== exp_vec(cyc)) begin
        errors++;
        $display("FAIL same_sel_after cyc=%0d got=%b required=%b", cyc, obs, exp_vec(cyc));
      end
    end
  endtask

  task automatic test_err;
    for (int k = 6; k < 8; k++) begin
      REQ_SEL = 3'(k);
      REQ_VALID = 1'b1;
      model_accept(cyc, 3'(k));
      @(negedge CLK);
      REQ_VALID = 1'b0;
      checks++;
      if ({ERR, ACK, CLK_EN, BUSY} !== 4'b1010 || DIV_SEL !== RSEL) begin
        errors++;
        $display("FAIL err_pulse sel=%0d got ERR,ACK,CLK_EN,BUSY=%b DIV_SEL=%0d required=1010 %0d",
                 k, {ERR, ACK, CLK_EN, BUSY}, DIV_SEL, RSEL);
      end
      @(negedge CLK);
      checks++;
      if (obs !== exp_vec(cyc) || ERR !== 1'b0) begin
        errors++;
        $display("FAIL err_after sel=%0d got=%b required=%b", k, obs, exp_vec(cyc));
      end
    end
  endtask

  task automatic test_switch;
    int a, div_chg, ack_seen;
    logic [2:0] prev_div;
    for (int i = 0; i < 64 && (cyc % 32) != 2; i++) @(negedge CLK);
    checks++;
    if ((cyc % 32) != 2) begin
      errors++;
      $display("FAIL switch_phase_wait got phase=%0d required=2", cyc % 32);
    end
    a = cyc; div_chg = -1; ack_seen = -1; prev_div = DIV_SEL;
    REQ_SEL = 3'd3;
    REQ_VALID = 1'b1;
    model_accept(a, 3'd3);
    for (int i = 0; i < 45; i++) begin
      @(negedge CLK);
      REQ_VALID = 1'b0;
      checks++;
      if (obs !== exp_vec(cyc)) begin
        errors++;
        $display("FAIL switch_model cyc=%0d got=%b required=%b", cyc, obs, exp_vec(cyc));
      end
      if (DIV_SEL !== prev_div) begin
        div_chg = cyc;
        checks++;
        if (CLK_EN !== 1'b0) begin
          errors++;
          $display("FAIL switch_glitch cyc=%0d got CLK_EN=%b required=0", cyc, CLK_EN);
        end
      end
      if (ACK === 1'b1 && ack_seen < 0) ack_seen = cyc;
      if (cyc == a + 1) begin
        checks++;
        if (CLK_EN !== 1'b0) begin
          errors++;
          $display("FAIL switch_gate_fall got CLK_EN=%b required=0", CLK_EN);
        end
      end
      prev_div = DIV_SEL;
    end
    checks++;
    if (div_chg != a + 31) begin
      errors++;
      $display("FAIL switch_div_time got=%0d required=%0d", div_chg - a, 31);
    end
    checks++;
    if (ack_seen != a + 33 || prev_div !== 3'd3) begin
      errors++;
      $display("FAIL switch_ack_time got=%0d sel=%0d required=33 sel=3", ack_seen - a, prev_div);
    end
  endtask

  task automatic test_random;
    int done, budget;
    bit acc, idle_now;
    logic [7:0] e;
    done = 0; budget = 0; acc = 0; idle_now = 0;
    REQ_VALID = 1'b0;
    while (budget < 6000 && !(done >= 30 && !REQ_VALID && idle_now)) begin
      @(negedge CLK);
      budget++;
      e = exp_vec(cyc);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL random cyc=%0d got=%b required=%b", cyc, obs, e);
      end
      idle_now = !e[3];
      if (acc) begin
        REQ_VALID = 1'b0;
        acc = 0;
      end
      if (!REQ_VALID) begin
        REQ_SEL = 3'($urandom_range(0, 7));
        if (done < 30 && $urandom_range(0, 2) == 0) REQ_VALID = 1'b1;
      end
      if (REQ_VALID && e[2]) begin
        model_accept(cyc, REQ_SEL);
        acc = 1;
        done++;
      end
    end
    checks++;
    if (done < 30 || REQ_VALID) begin
      errors++;
      $display("FAIL random_budget got accepted=%0d required=30", done);
    end
  endtask

  task automatic test_reset_abort;
    do_reset();
    REQ_SEL = 3'd5;
    REQ_VALID = 1'b1;
    model_accept(cyc, 3'd5);
    for (int i = 0; i < 20 && cyc != m_a + G + 3; i++) begin
      @(negedge CLK);
      REQ_VALID = 1'b0;
    end
    checks++;
    if (cyc != m_a + G + 3 || {CLK_EN, BUSY} !== 2'b01) begin
      errors++;
      $display("FAIL abort_in_align got CLK_EN,BUSY=%b required=01", {CLK_EN, BUSY});
    end
    RESET = 1'b1;
    @(negedge CLK);
    checks++;
    if (obs !== {RSEL, 5'b10100}) begin
      errors++;
      $display("FAIL abort_reset_vals got=%b required=%b", obs, {RSEL, 5'b10100});
    end
    RESET = 1'b0;
    model_reset();
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      checks++;
      if (ACK !== 1'b0 || obs !== exp_vec(cyc)) begin
        errors++;
        $display("FAIL abort_after cyc=%0d got=%b required=%b", cyc, obs, exp_vec(cyc));
      end
    end
  endtask
`endif

`ifdef AHA_CLK_SEL_PENDING_EN
  task automatic test_pending;
    int acks, extra;
    do_reset();
    REQ_SEL = 3'd2;
    REQ_VALID = 1'b1;
    @(negedge CLK);
    checks++;
    if (REQ_READY !== 1'b1 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL pend_ready_empty got READY,BUSY=%b required=11", {REQ_READY, BUSY});
    end
    REQ_SEL = 3'd4;
    @(negedge CLK);
    checks++;
    if (REQ_READY !== 1'b0) begin
      errors++;
      $display("FAIL pend_ready_full got=%b required=0", REQ_READY);
    end
    REQ_SEL = 3'd1;
    @(negedge CLK);
    checks++;
    if (REQ_READY !== 1'b0) begin
      errors++;
      $display("FAIL pend_third_held got=%b required=0", REQ_READY);
    end
    REQ_VALID = 1'b0;
    acks = 0;
    for (int i = 0; i < 300 && acks < 2; i++) begin
      @(negedge CLK);
      if (ACK === 1'b1) begin
        acks++;
        checks++;
        if (DIV_SEL !== ((acks == 1) ? 3'd2 : 3'd4)) begin
          errors++;
          $display("FAIL pend_ack_order ack=%0d got sel=%0d", acks, DIV_SEL);
        end
      end
    end
    extra = 0;
    repeat (60) begin
      @(negedge CLK);
      if (ACK === 1'b1) extra++;
    end
    checks++;
    if (acks != 2 || extra != 0 || DIV_SEL !== 3'd4) begin
      errors++;
      $display("FAIL pend_final got acks=%0d extra=%0d sel=%0d required 2 0 4", acks, extra, DIV_SEL);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef AHA_CLK_SEL_PENDING_EN
    test_pending();
`else
    test_same_sel();
    test_err();
    test_switch();
    test_random();
    test_reset_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
